// File: rtl/sprite_line_scheduler_if.sv
// Sprite scheduler bus: raster position, sprite-table writes,
// ROM fetch port and winning-pixel outputs.
// Ports (signals): DrawX/DrawY raster position, cfg_* table
//  write, rom_address/rom_q ROM port, pix_* winner, fetch_busy,
//  overrun. master = raster/game/ROM side, slave = scheduler.
interface sprite_line_scheduler_if #(
   parameter int ADDR_W = 8
);
   logic [9:0]        DrawX;
   logic [9:0]        DrawY;
   logic              cfg_we;
   logic [2:0]        cfg_idx;
   logic [9:0]        cfg_x;
   logic [9:0]        cfg_y;
   logic              cfg_en;
   logic [ADDR_W-1:0] rom_address;
   logic [1:0]        rom_q;
   logic [1:0]        pix_index;
   logic [2:0]        pix_id;
   logic              pix_hit;
   logic              fetch_busy;
   logic              overrun;

   modport master (
      output DrawX, DrawY,
      output cfg_we, cfg_idx, cfg_x, cfg_y, cfg_en,
      output rom_q,
      input  rom_address,
      input  pix_index, pix_id, pix_hit,
      input  fetch_busy, overrun
   );

   modport slave (
      input  DrawX, DrawY,
      input  cfg_we, cfg_idx, cfg_x, cfg_y, cfg_en,
      input  rom_q,
      output rom_address,
      output pix_index, pix_id, pix_hit,
      output fetch_busy, overrun
   );
endinterface

// File: rtl/sprite_line_scheduler.sv
// Shares one sprite ROM among NUM_SPRITES instances: fetches each
// sprite's row for the next line during hblank, then picks the
// lowest-numbered opaque sprite pixel during the active line.
// Ports: vga_clk pixel clock, Reset sync active-high,
//  bus (slave) carries raster, table, ROM and pixel signals.
module sprite_line_scheduler #(
   parameter int NUM_SPRITES = 4,
   parameter int SPR_W       = 14,
   parameter int SPR_H       = 14,
   parameter int ADDR_W      = 8,
   parameter int H_ACTIVE    = 640,
   parameter int H_TOTAL     = 800,
   parameter int V_ACTIVE    = 480,
   parameter int V_TOTAL     = 525
) (
   input logic                   vga_clk,
   input logic                   Reset,
   sprite_line_scheduler_if.slave bus
);

   localparam int SW = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
   localparam int CW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
   localparam int RW = (SPR_H > 1) ? $clog2(SPR_H) : 1;

   if (SPR_W * SPR_H > 2 ** ADDR_W) begin : g_bad_addr
      $error("sprite does not fit the ROM address space");
   end
   if (NUM_SPRITES < 1 || NUM_SPRITES > 8 ||
       NUM_SPRITES * (SPR_W + 2) > H_TOTAL - H_ACTIVE) begin : g_bad_n
      $error("sprite fetch does not fit in hblank");
   end

   typedef enum logic [1:0] {
      S_IDLE, S_SCAN, S_ADDR, S_LAST
   } state_t;

   state_t            state_q, state_d;
   logic [SW-1:0]     idx_q, idx_d;
   logic [9:0]        tgt_q, tgt_d;
   logic [RW-1:0]     row_q, row_d;
   logic [CW-1:0]     col_q, col_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              busy_q, busy_d;
   logic              ovr_q, ovr_d;

   logic [9:0] act_x_q [NUM_SPRITES];
   logic [9:0] act_x_d [NUM_SPRITES];
   logic [9:0] act_y_q [NUM_SPRITES];
   logic [9:0] act_y_d [NUM_SPRITES];
   logic       act_en_q [NUM_SPRITES];
   logic       act_en_d [NUM_SPRITES];
   logic [9:0] sh_x_q [NUM_SPRITES];
   logic [9:0] sh_x_d [NUM_SPRITES];
   logic [9:0] sh_y_q [NUM_SPRITES];
   logic [9:0] sh_y_d [NUM_SPRITES];
   logic       sh_en_q [NUM_SPRITES];
   logic       sh_en_d [NUM_SPRITES];

   logic [1:0] rowbuf_q [NUM_SPRITES][SPR_W];
   logic [1:0] rowbuf_d [NUM_SPRITES][SPR_W];
   logic [NUM_SPRITES-1:0] rv_q, rv_d;

   logic [1:0] pix_index_q, pix_index_d;
   logic [2:0] pix_id_q, pix_id_d;
   logic       pix_hit_q, pix_hit_d;

   logic              abort;
   logic signed [10:0] diff;
   logic              fits;
   logic [CW-1:0]     colm1;
   logic [ADDR_W-1:0] addr_now;
   logic              last_spr;

   logic [NUM_SPRITES-1:0] cov;
   logic [CW-1:0]          offs [NUM_SPRITES];
   logic [1:0]             spx [NUM_SPRITES];
   logic [10:0]            dx11;

   // Sprite tables: cfg writes go to the active copy; the shadow
   // copy used by fetch and output is refreshed once per frame.
   always_comb begin
      act_x_d  = act_x_q;
      act_y_d  = act_y_q;
      act_en_d = act_en_q;
      sh_x_d   = sh_x_q;
      sh_y_d   = sh_y_q;
      sh_en_d  = sh_en_q;
      for (int i = 0; i < NUM_SPRITES; i++) begin
         if (bus.cfg_we && int'(bus.cfg_idx) == i) begin
            act_x_d[i]  = bus.cfg_x;
            act_y_d[i]  = bus.cfg_y;
            act_en_d[i] = bus.cfg_en;
         end
      end
      if (bus.DrawX == 10'd0 && bus.DrawY == 10'(V_ACTIVE)) begin
         sh_x_d  = act_x_q;
         sh_y_d  = act_y_q;
         sh_en_d = act_en_q;
      end
   end

   // Row fetch FSM
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      tgt_d    = tgt_q;
      row_d    = row_q;
      col_d    = col_q;
      addr_d   = addr_q;
      ovr_d    = ovr_q;
      rv_d     = rv_q;
      rowbuf_d = rowbuf_q;

      diff     = $signed({1'b0, tgt_q}) - $signed({1'b0, sh_y_q[idx_q]});
      fits     = sh_en_q[idx_q] && !diff[10] &&
                 (diff[9:0] <= 10'(SPR_H - 1));
      colm1    = col_q - CW'(1);
      addr_now = ADDR_W'(int'(row_q) * SPR_W + int'(col_q));
      last_spr = (idx_q == SW'(NUM_SPRITES - 1));
      abort    = busy_q && (bus.DrawX == 10'd0);

      bus.rom_address = addr_q;

      if (abort) begin
         // Line started before the fetch finished: drop the
         // in-progress sprite and every later one.
         ovr_d   = 1'b1;
         state_d = S_IDLE;
         for (int i = 0; i < NUM_SPRITES; i++) begin
            if (i >= int'(idx_q)) rv_d[i] = 1'b0;
         end
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (bus.DrawX == 10'(H_ACTIVE)) begin
                  tgt_d   = (bus.DrawY == 10'(V_TOTAL - 1)) ?
                            10'd0 : bus.DrawY + 10'd1;
                  idx_d   = '0;
                  state_d = S_SCAN;
               end
            end
            S_SCAN: begin
               rv_d[idx_q] = 1'b0;
               if (fits) begin
                  row_d   = diff[RW-1:0];
                  col_d   = '0;
                  state_d = S_ADDR;
               end else if (last_spr) begin
                  state_d = S_IDLE;
               end else begin
                  idx_d = idx_q + SW'(1);
               end
            end
            S_ADDR: begin
               bus.rom_address = addr_now;
               addr_d          = addr_now;
               // rom_q now holds the word addressed last cycle
               if (col_q != '0) rowbuf_d[idx_q][colm1] = bus.rom_q;
               if (col_q == CW'(SPR_W - 1)) state_d = S_LAST;
               else col_d = col_q + CW'(1);
            end
            S_LAST: begin
               rowbuf_d[idx_q][SPR_W-1] = bus.rom_q;
               rv_d[idx_q] = 1'b1;
               if (last_spr) state_d = S_IDLE;
               else begin
                  idx_d   = idx_q + SW'(1);
                  state_d = S_SCAN;
               end
            end
         endcase
      end

      busy_d = (state_d != S_IDLE);
   end

   // Per-sprite coverage of the current column; the offset only
   // matters when covered, so low bits of DrawX - x suffice.
   always_comb begin
      dx11 = {1'b0, bus.DrawX};
      for (int i = 0; i < NUM_SPRITES; i++) begin
         cov[i]  = rv_q[i] &&
                   dx11 >= {1'b0, sh_x_q[i]} &&
                   dx11 <= {1'b0, sh_x_q[i]} + 11'(SPR_W - 1);
         offs[i] = cov[i] ?
                   (bus.DrawX[CW-1:0] - sh_x_q[i][CW-1:0]) : '0;
         spx[i]  = cov[i] ? rowbuf_q[i][offs[i]] : 2'b00;
      end
   end

   // Winner select: walk downwards so the lowest index wins.
   always_comb begin
      pix_hit_d   = 1'b0;
      pix_index_d = 2'b00;
      pix_id_d    = 3'd0;
      if (bus.DrawX < 10'(H_ACTIVE) && bus.DrawY < 10'(V_ACTIVE)) begin
         for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (spx[i] != 2'b00) begin
               pix_hit_d   = 1'b1;
               pix_index_d = spx[i];
               pix_id_d    = 3'(i);
            end
         end
      end
   end

   always_ff @(posedge vga_clk) begin
      if (Reset) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         tgt_q       <= '0;
         row_q       <= '0;
         col_q       <= '0;
         addr_q      <= '0;
         busy_q      <= 1'b0;
         ovr_q       <= 1'b0;
         act_x_q     <= '{default: '0};
         act_y_q     <= '{default: '0};
         act_en_q    <= '{default: '0};
         sh_x_q      <= '{default: '0};
         sh_y_q      <= '{default: '0};
         sh_en_q     <= '{default: '0};
         rowbuf_q    <= '{default: '0};
         rv_q        <= '0;
         pix_index_q <= '0;
         pix_id_q    <= '0;
         pix_hit_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         tgt_q       <= tgt_d;
         row_q       <= row_d;
         col_q       <= col_d;
         addr_q      <= addr_d;
         busy_q      <= busy_d;
         ovr_q       <= ovr_d;
         act_x_q     <= act_x_d;
         act_y_q     <= act_y_d;
         act_en_q    <= act_en_d;
         sh_x_q      <= sh_x_d;
         sh_y_q      <= sh_y_d;
         sh_en_q     <= sh_en_d;
         rowbuf_q    <= rowbuf_d;
         rv_q        <= rv_d;
         pix_index_q <= pix_index_d;
         pix_id_q    <= pix_id_d;
         pix_hit_q   <= pix_hit_d;
      end
   end

   assign bus.pix_index  = pix_index_q;
   assign bus.pix_id     = pix_id_q;
   assign bus.pix_hit    = pix_hit_q;
   assign bus.fetch_busy = busy_q;
   assign bus.overrun    = ovr_q;

endmodule

// File: tb/tb_sprite_line_scheduler.sv
// Bench for sprite_line_scheduler: constant vector table plus
// full-line sweeps checked against a frame-level sprite model.
module tb_sprite_line_scheduler;

   localparam int N  = 8;
   localparam int SW = 14;
   localparam int SH = 14;
   localparam int AW = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   sprite_line_scheduler_if #(.ADDR_W(AW)) bus ();

   sprite_line_scheduler #(
      .NUM_SPRITES(N), .SPR_W(SW), .SPR_H(SH), .ADDR_W(AW),
      .H_ACTIVE(640), .H_TOTAL(800), .V_ACTIVE(480), .V_TOTAL(525)
   ) dut (
      .vga_clk(clk),
      .Reset(rst),
      .bus(bus.slave)
   );

   logic [1:0] rom [256];
   always @(posedge clk) bus.rom_q <= rom[bus.rom_address];

   int m_ax [N];
   int m_ay [N];
   bit m_ae [N];
   int m_sx [N];
   int m_sy [N];
   bit m_se [N];
   bit m_mask [N];
   int m_line;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      int line;
      int col;
      int hit;
      int idx;
      int id;
   } vec_t;
   vec_t tv [11];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic int pix_now();
      return (int'(bus.pix_hit) << 5) | (int'(bus.pix_index) << 3) |
             int'(bus.pix_id);
   endfunction

   // Expected pixel from the frame-level rules: highest-priority
   // enabled sprite whose box holds the fetched line and column.
   function automatic int exp_pix(input int x, input int y);
      int v;
      if (x >= 640 || y >= 480) return 0;
      for (int i = 0; i < N; i++) begin
         if (m_mask[i] && m_se[i] &&
             m_line >= m_sy[i] && m_line <= m_sy[i] + SH - 1 &&
             x >= m_sx[i] && x <= m_sx[i] + SW - 1) begin
            v = rom[(m_line - m_sy[i]) * SW + x - m_sx[i]];
            if (v != 0) return (1 << 5) | (v << 3) | i;
         end
      end
      return 0;
   endfunction

   task automatic park();
      bus.DrawX = 10'd700;
      bus.DrawY = 10'd0;
   endtask

   task automatic cfg_write(input int i, input int x, input int y,
                            input bit en);
      bus.cfg_we  = 1'b1;
      bus.cfg_idx = 3'(i);
      bus.cfg_x   = 10'(x);
      bus.cfg_y   = 10'(y);
      bus.cfg_en  = en;
      tick();
      bus.cfg_we = 1'b0;
      m_ax[i] = x;
      m_ay[i] = y;
      m_ae[i] = en;
   endtask

   task automatic copy_model();
      for (int i = 0; i < N; i++) begin
         m_sx[i] = m_ax[i];
         m_sy[i] = m_ay[i];
         m_se[i] = m_ae[i];
      end
   endtask

   task automatic copy_tables();
      bus.DrawX = 10'd0;
      bus.DrawY = 10'd480;
      tick();
      copy_model();
      park();
   endtask

   task automatic clear_all();
      for (int i = 0; i < N; i++) cfg_write(i, 0, 0, 1'b0);
   endtask

   task automatic hblank(input int ly);
      for (int x = 640; x < 800; x++) begin
         bus.DrawY = 10'(ly);
         bus.DrawX = 10'(x);
         tick();
         if (x == 641 || x == 643)
            chk($sformatf("blank_pix x=%0d", x), pix_now(), 0);
      end
      m_line = (ly == 524) ? 0 : ly + 1;
      for (int i = 0; i < N; i++) m_mask[i] = 1'b1;
      park();
   endtask

   task automatic probe(input int x, input int y, output int p);
      bus.DrawY = 10'(y);
      bus.DrawX = 10'(x);
      tick();
      p = pix_now();
      park();
   endtask

   task automatic sweep(input int y, input int x0, input string nm);
      bus.DrawY = 10'(y);
      for (int x = x0; x < 640; x++) begin
         bus.DrawX = 10'(x);
         tick();
         chk($sformatf("%s y=%0d x=%0d", nm, y, x), pix_now(),
             exp_pix(x, y));
      end
      park();
   endtask

   initial begin
      int p;
      int t;
      int cost;
      int ln;

      bus.cfg_we = 1'b0;
      bus.cfg_idx = '0;
      bus.cfg_x = '0;
      bus.cfg_y = '0;
      bus.cfg_en = 1'b0;
      park();
      for (int k = 0; k < 256; k++) rom[k] = 2'(k % 4);
      for (int i = 0; i < N; i++) begin
         m_ax[i] = 0; m_ay[i] = 0; m_ae[i] = 0;
         m_sx[i] = 0; m_sy[i] = 0; m_se[i] = 0;
         m_mask[i] = 0;
      end
      m_line = -1;

      tv[0]  = '{50, 100, 0, 0, 0};
      tv[1]  = '{50, 101, 1, 1, 0};
      tv[2]  = '{50, 113, 1, 1, 0};
      tv[3]  = '{50, 114, 0, 0, 0};
      tv[4]  = '{51, 100, 1, 2, 0};
      tv[5]  = '{63, 113, 1, 3, 0};
      tv[6]  = '{63, 112, 1, 2, 0};
      tv[7]  = '{49, 101, 0, 0, 0};
      tv[8]  = '{64, 101, 0, 0, 0};
      tv[9]  = '{52, 99, 0, 0, 0};
      tv[10] = '{52, 102, 1, 2, 0};

      repeat (3) tick();
      rst = 1'b0;
      tick();
      chk("reset rom_address", int'(bus.rom_address), 0);
      chk("reset pix", pix_now(), 0);
      chk("reset fetch_busy", int'(bus.fetch_busy), 0);
      chk("reset overrun", int'(bus.overrun), 0);

      // Test 1: one sprite, ROM word k = k%4
      cfg_write(0, 100, 50, 1'b1);
      copy_tables();
      foreach (tv[v]) begin
         hblank(tv[v].line - 1);
         probe(tv[v].col, tv[v].line, p);
         chk($sformatf("vec%0d", v), p,
             (tv[v].hit << 5) | (tv[v].idx << 3) | tv[v].id);
      end
      hblank(56);
      sweep(57, 0, "t1");

      // Test 2: overlapping opaque sprites 0 and 2
      for (int k = 0; k < 256; k++) rom[k] = 2'd3;
      cfg_write(0, 200, 200, 1'b1);
      cfg_write(2, 200, 200, 1'b1);
      copy_tables();
      hblank(204);
      probe(207, 205, p);
      chk("t2 sprite0 wins", p, (1 << 5) | (3 << 3) | 0);
      hblank(204);
      sweep(205, 0, "t2a");
      bus.DrawY = 10'd490;
      cfg_write(0, 200, 200, 1'b0);
      copy_tables();
      hblank(204);
      probe(207, 205, p);
      chk("t2 sprite2 after disable", p, (1 << 5) | (3 << 3) | 2);
      hblank(204);
      sweep(205, 0, "t2b");

      // Test 3: write in the same cycle as the shadow copy
      cfg_write(2, 0, 0, 1'b0);
      cfg_write(1, 300, 100, 1'b1);
      copy_tables();
      bus.DrawX = 10'd0;
      bus.DrawY = 10'd480;
      bus.cfg_we = 1'b1;
      bus.cfg_idx = 3'd1;
      bus.cfg_x = 10'd400;
      bus.cfg_y = 10'd100;
      bus.cfg_en = 1'b1;
      tick();
      bus.cfg_we = 1'b0;
      copy_model();
      m_ax[1] = 400;
      park();
      hblank(104);
      probe(305, 105, p);
      chk("t3 frame1 old pos", p, (1 << 5) | (3 << 3) | 1);
      hblank(104);
      probe(405, 105, p);
      chk("t3 frame1 new pos", p, 0);
      copy_tables();
      hblank(104);
      probe(405, 105, p);
      chk("t3 frame2 new pos", p, (1 << 5) | (3 << 3) | 1);
      hblank(104);
      probe(305, 105, p);
      chk("t3 frame2 old pos", p, 0);

      // Test 4: right-edge clipping
      cfg_write(1, 0, 0, 1'b0);
      cfg_write(3, 630, 10, 1'b1);
      copy_tables();
      hblank(14);
      for (int x = 0; x < 4; x++) begin
         probe(x, 15, p);
         chk($sformatf("t4 no wrap x=%0d", x), p, 0);
      end
      probe(639, 15, p);
      chk("t4 x=639", p, (1 << 5) | (3 << 3) | 3);
      probe(629, 15, p);
      chk("t4 x=629", p, 0);
      sweep(15, 0, "t4");
      hblank(15);

      // Line 0 fetched from the last line; no vertical wrap
      for (int k = 0; k < 256; k++) rom[k] = 2'($urandom_range(0, 3));
      clear_all();
      cfg_write(4, 50, 520, 1'b1);
      cfg_write(5, 100, 0, 1'b1);
      cfg_write(6, 120, 1020, 1'b1);
      copy_tables();
      hblank(524);
      sweep(0, 0, "line0");

      // Random sprite tables
      for (int r = 0; r < 6; r++) begin
         for (int k = 0; k < 256; k++) rom[k] = 2'($urandom_range(0, 3));
         ln = $urandom_range(20, 470);
         for (int i = 0; i < N; i++)
            cfg_write(i, $urandom_range(0, 650),
                      ln - 16 + $urandom_range(0, 20),
                      ($urandom_range(0, 3) != 0));
         copy_tables();
         hblank(ln - 1);
         sweep(ln, 0, $sformatf("rnd%0d", r));
      end

      // Test 5: all eight sprites on one line, then overrun
      for (int k = 0; k < 256; k++) rom[k] = 2'($urandom_range(1, 3));
      for (int i = 0; i < N; i++) cfg_write(i, 20 + 70 * i, 300, 1'b1);
      copy_tables();
      for (int x = 640; x < 800; x++) begin
         bus.DrawY = 10'd300;
         bus.DrawX = 10'(x);
         tick();
         if (x == 700) chk("t5 busy mid", int'(bus.fetch_busy), 1);
         if (x == 768) begin
            chk("t5 busy by 768", int'(bus.fetch_busy), 0);
            chk("t5 no overrun", int'(bus.overrun), 0);
         end
      end
      m_line = 301;
      for (int i = 0; i < N; i++) m_mask[i] = 1'b1;
      park();
      sweep(301, 0, "t5full");
      for (int x = 640; x <= 700; x++) begin
         bus.DrawY = 10'd300;
         bus.DrawX = 10'(x);
         tick();
      end
      chk("t5 busy before cut", int'(bus.fetch_busy), 1);
      bus.DrawX = 10'd0;
      bus.DrawY = 10'd301;
      tick();
      chk("t5 overrun set", int'(bus.overrun), 1);
      chk("t5 busy after cut", int'(bus.fetch_busy), 0);
      // Sprite fetches start one cycle after DrawX=640 and must
      // finish before the cycle that sees DrawX=0 (cycle 701).
      t = 641;
      for (int i = 0; i < N; i++) begin
         cost = (m_se[i] && m_line >= m_sy[i] &&
                 m_line <= m_sy[i] + SH - 1) ? SW + 2 : 1;
         m_mask[i] = (t + cost - 1 < 701);
         t += cost;
      end
      sweep(301, 1, "t5cut");
      chk("t5 overrun sticky", int'(bus.overrun), 1);

      // Test 6: reset in the 5th ADDR cycle
      for (int k = 0; k < 256; k++) rom[k] = 2'(k % 4);
      clear_all();
      cfg_write(0, 100, 300, 1'b1);
      copy_tables();
      for (int x = 640; x <= 646; x++) begin
         bus.DrawY = 10'd305;
         bus.DrawX = 10'(x);
         if (x == 646) begin
            #1;
            chk("t6 rom_address", int'(bus.rom_address), 6 * SW + 4);
            rst = 1'b1;
         end
         tick();
      end
      rst = 1'b0;
      chk("t6 rom_address", int'(bus.rom_address), 0);
      chk("t6 pix", pix_now(), 0);
      chk("t6 fetch_busy", int'(bus.fetch_busy), 0);
      chk("t6 overrun", int'(bus.overrun), 0);
      for (int i = 0; i < N; i++) begin
         m_ax[i] = 0; m_ay[i] = 0; m_ae[i] = 0;
         m_mask[i] = 0;
      end
      copy_model();
      park();
      bus.DrawY = 10'd306;
      sweep(306, 0, "t6after");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
